exe_cmd_issuer: RTL and testbench
=================================

Name: exe_cmd_issuer

Overview:
Command-side companion to the execution unit. It accepts operation commands (oper, argA, argB) from upstream over a valid/ready handshake and buffers them in a small FIFO. It drives them one at a time onto the execution unit's operand/opcode inputs, waits the unit's fixed latency, and captures the registered result and status. The captured pair is returned upstream over a valid/ready response handshake, with a saturating count of non-zero statuses.

Parameters:
m, 4, operand/result width in bits
n, 2, opcode width in bits
depth, 4, command FIFO depth (power of 2, >= 2)
lat, 1, execution-unit register stages between operand sampling and result (>= 1)
cntw, 8, width of error counter

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset: one clock, synchronous, active-high
i_cmd_valid  in  1  upstream command valid
o_cmd_ready  out  1  FIFO can accept (= not full)
i_cmd_oper  in  n  command opcode
i_cmd_argA  in  m  signed operand A
i_cmd_argB  in  m  signed operand B
o_x_oper  out  n  opcode driven to execution unit (registered)
o_x_argA  out  m  operand A to execution unit (registered)
o_x_argB  out  m  operand B to execution unit (registered)
i_x_result  in  m  execution unit result
i_x_status  in  2  execution unit status
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  downstream accepts response
o_rsp_result  out  m  captured result
o_rsp_status  out  2  captured status
o_rsp_oper  out  n  opcode the response belongs to
o_busy  out  1  high in WAIT or RESP
o_err_cnt  out  cntw  saturating count of accepted responses with status != 0

Behaviour:
- Reset (i_rst high at an edge):
  - FIFO emptied; FSM to IDLE; wait counter 0.
  - All outputs 0 except o_cmd_ready, which is 1 in the cycle after reset.
  - Any in-flight command or held response is discarded.
  - Reset overrides all other activity in the same cycle.
- FIFO:
  - Push on edge when i_cmd_valid && o_cmd_ready. o_cmd_ready = (count != depth), combinational from count.
  - Pop happens only on the FSM issue edge.
  - Push and pop on the same edge: both take effect and count is unchanged.
  - No fall-through: a command pushed at edge e can be popped at edge e+1 at the earliest.
  - Pointers wrap modulo depth. Count is held in log2(depth)+1 bits.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty at an edge, pop the head.
  - Load o_x_oper/argA/argB and an internal copy of oper; set counter = lat; go to WAIT.
- WAIT:
  - o_x_* hold their value.
  - Each edge with counter != 0: decrement.
  - Edge with counter == 0: capture i_x_result/i_x_status into o_rsp_result/o_rsp_status, copy oper to o_rsp_oper, go to RESP.
  - Result: with lat=1, if the issue edge is t, capture is at edge t+2 (the unit samples at t+1).
- RESP:
  - o_rsp_valid = 1. o_rsp_* are stable until the handshake.
  - Handshake edge (i_rsp_ready high): if o_rsp_status != 0 and o_err_cnt != all-ones, o_err_cnt increments.
  - Then, if the FIFO is non-empty, pop and issue as in IDLE (straight to WAIT); else go to IDLE.
  - After the handshake, o_rsp_valid drops unless the next response is ready, which cannot happen for lat >= 1. So o_rsp_valid is low for at least lat+1 cycles between responses.
- Only one command is outstanding at a time. No pipelining across the execution unit.
- Arguments pass through bit-exact. No sign extension or width change.
- o_x_* keep the last issued command in IDLE (not cleared) except at reset.
- o_busy = (state != IDLE).
- o_err_cnt saturates at 2^cntw-1 and is cleared only by reset.

Test Plan:
Bench responder models the unit with lat=1: result = (argA+argB) mod 2^m, status = oper, sampled on posedge.
- Single command: oper=2'b01, A=3, B=2 pushed at edge 1 → o_x_* loaded at edge 2, o_rsp_valid high after edge 4 with result=5, status=01, oper=01; o_err_cnt=1 after the handshake.
- Back-to-back: 4 commands pushed on consecutive cycles with i_rsp_ready tied 1 → o_cmd_ready never drops. Responses arrive in order, each separated by 3 cycles. Results are A+B for A/B pairs (1,1), (2,−1), (7,1)→wrap −8, (−8,−8)→0.
- FIFO full: hold i_rsp_ready=0 and push 6 commands → the first is issued, the next 4 fill the FIFO, and o_cmd_ready=0 while the 6th is held. Raising i_rsp_ready → one slot frees and the 6th is accepted; order is preserved.
- Response backpressure: i_rsp_ready low for 10 cycles in RESP → o_rsp_result/status/oper unchanged and o_x_* unchanged; the next command is not issued until the handshake.
- Reset mid-WAIT and mid-RESP with 2 commands queued → next cycle: o_rsp_valid=0, o_busy=0, o_cmd_ready=1, o_err_cnt=0. No stale response appears afterward.
- Error counter saturation (cntw=2): 5 responses with status=2'b11 → o_err_cnt = 3 and stays at 3.

Source files
------------

// File: rtl/exe_cmd_issuer.sv
// Command issuer for a fixed-latency execution unit: buffers commands in a FIFO,
// issues one at a time, waits lat cycles, and returns result/status upstream.
module exe_cmd_issuer #(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int depth = 4,
  parameter int lat   = 1,
  parameter int cntw  = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [n-1:0]    i_cmd_oper,
  input  logic [m-1:0]    i_cmd_argA,
  input  logic [m-1:0]    i_cmd_argB,
  output logic [n-1:0]    o_x_oper,
  output logic [m-1:0]    o_x_argA,
  output logic [m-1:0]    o_x_argB,
  input  logic [m-1:0]    i_x_result,
  input  logic [1:0]      i_x_status,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [m-1:0]    o_rsp_result,
  output logic [1:0]      o_rsp_status,
  output logic [n-1:0]    o_rsp_oper,
  output logic            o_busy,
  output logic [cntw-1:0] o_err_cnt
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam int LW = (lat > 1) ? $clog2(lat + 1) : 1;
  localparam int EW = n + 2 * m;

  // Handshakes: a command transfers on an edge with i_cmd_valid && o_cmd_ready;
  // a response transfers on an edge with o_rsp_valid && i_rsp_ready. Neither
  // valid may depend on its ready, and o_rsp_* are stable while o_rsp_valid waits.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [LW-1:0]   r_wait;
  logic [n-1:0]    r_oper;

  logic [EW-1:0]   r_mem [depth];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_fifo_ne;
  logic [EW-1:0]   w_head;
  logic [n-1:0]    w_head_oper;
  logic [m-1:0]    w_head_argA;
  logic [m-1:0]    w_head_argB;

  assign o_cmd_ready = (r_count != CW'(depth));
  assign w_fifo_ne   = (r_count != '0);
  assign w_push      = i_cmd_valid && o_cmd_ready;
  // Pop only when the FSM issues: from IDLE, or straight out of RESP on the handshake.
  assign w_pop       = w_fifo_ne &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && i_rsp_ready));

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_oper = w_head[2*m +: n];
  assign w_head_argA = w_head[m +: m];
  assign w_head_argB = w_head[0 +: m];

  assign o_busy      = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_mem[r_wr_ptr] <= {i_cmd_oper, i_cmd_argA, i_cmd_argB};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_oper       <= '0;
      o_x_oper     <= '0;
      o_x_argA     <= '0;
      o_x_argB     <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_status <= '0;
      o_rsp_oper   <= '0;
      o_err_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            o_x_oper <= w_head_oper;
            o_x_argA <= w_head_argA;
            o_x_argB <= w_head_argB;
            r_oper   <= w_head_oper;
            r_wait   <= LW'(lat);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - LW'(1);
          end else begin
            o_rsp_result <= i_x_result;
            o_rsp_status <= i_x_status;
            o_rsp_oper   <= r_oper;
            o_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            if ((o_rsp_status != 2'b00) && (o_err_cnt != '1)) begin
              o_err_cnt <= o_err_cnt + cntw'(1);
            end
            if (w_pop) begin
              o_x_oper <= w_head_oper;
              o_x_argA <= w_head_argA;
              o_x_argB <= w_head_argB;
              r_oper   <= w_head_oper;
              r_wait   <= LW'(lat);
              r_state  <= S_WAIT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_cmd_issuer.sv
// Directed bench for exe_cmd_issuer with a lat=1 adder responder
// (result = A+B mod 16, status = oper) and an in-order response scoreboard.
module tb_exe_cmd_issuer;

  localparam int M  = 4;
  localparam int N  = 2;
  localparam int CW = 2;
  localparam int W  = M + 2 + N;

  logic          i_clk;
  logic          i_rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [N-1:0]  i_cmd_oper;
  logic [M-1:0]  i_cmd_argA;
  logic [M-1:0]  i_cmd_argB;
  logic [N-1:0]  o_x_oper;
  logic [M-1:0]  o_x_argA;
  logic [M-1:0]  o_x_argB;
  logic [M-1:0]  i_x_result;
  logic [1:0]    i_x_status;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [M-1:0]  o_rsp_result;
  logic [1:0]    o_rsp_status;
  logic [N-1:0]  o_rsp_oper;
  logic          o_busy;
  logic [CW-1:0] o_err_cnt;

  exe_cmd_issuer #(.m(M), .n(N), .depth(4), .lat(1), .cntw(CW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_oper   (i_cmd_oper),
    .i_cmd_argA   (i_cmd_argA),
    .i_cmd_argB   (i_cmd_argB),
    .o_x_oper     (o_x_oper),
    .o_x_argA     (o_x_argA),
    .o_x_argB     (o_x_argB),
    .i_x_result   (i_x_result),
    .i_x_status   (i_x_status),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_result (o_rsp_result),
    .o_rsp_status (o_rsp_status),
    .o_rsp_oper   (o_rsp_oper),
    .o_busy       (o_busy),
    .o_err_cnt    (o_err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Execution unit model: one register stage.
  always @(posedge i_clk) begin
    i_x_result <= o_x_argA + o_x_argB;
    i_x_status <= o_x_oper;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [N-1:0] oper;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] res;
  } vec_t;

  vec_t tbl [12];

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int           hs_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge i_clk) begin
    if (i_rst === 1'b0 && o_rsp_valid === 1'b1 && i_rsp_ready === 1'b1) begin
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %0h expected none",
                 {o_rsp_result, o_rsp_status, o_rsp_oper});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("rsp_data", 32'({o_rsp_result, o_rsp_status, o_rsp_oper}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    tick();
    i_rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push(input int idx, input int budget, output int waits);
    waits       = 0;
    i_cmd_valid = 1'b1;
    i_cmd_oper  = tbl[idx].oper;
    i_cmd_argA  = tbl[idx].a;
    i_cmd_argB  = tbl[idx].b;
    while (!o_cmd_ready && waits < budget) begin
      tick();
      waits++;
    end
    if (!o_cmd_ready) begin
      i_cmd_valid = 1'b0;
      total++;
      bad++;
      $display("FAIL push_timeout: got cmd_ready=0 expected 1 within %0d cycles", budget);
    end else begin
      exp_q.push_back({tbl[idx].res, tbl[idx].oper, tbl[idx].oper});
      tick();
      i_cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!o_rsp_valid && k < budget) begin
      tick();
      k++;
    end
    check("wait_rsp_valid", 32'(o_rsp_valid), 32'd1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || o_rsp_valid) && k < budget) begin
      tick();
      k++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !o_rsp_valid), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    check({tag, "_busy"},      32'(o_busy),      32'd0);
    check({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
    check({tag, "_err_cnt"},   32'(o_err_cnt),   32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int w;
    tbl[0]  = '{2'b01, 4'h3, 4'h2, 4'h5};
    tbl[1]  = '{2'b00, 4'h1, 4'h1, 4'h2};
    tbl[2]  = '{2'b01, 4'h2, 4'hF, 4'h1};
    tbl[3]  = '{2'b10, 4'h7, 4'h1, 4'h8};
    tbl[4]  = '{2'b11, 4'h8, 4'h8, 4'h0};
    tbl[5]  = '{2'b00, 4'h5, 4'h6, 4'hB};
    tbl[6]  = '{2'b10, 4'h4, 4'h4, 4'h8};
    tbl[7]  = '{2'b00, 4'hF, 4'hF, 4'hE};
    tbl[8]  = '{2'b01, 4'h6, 4'h9, 4'hF};
    tbl[9]  = '{2'b00, 4'h0, 4'h0, 4'h0};
    tbl[10] = '{2'b11, 4'hA, 4'h3, 4'hD};
    tbl[11] = '{2'b11, 4'h1, 4'h2, 4'h3};

    i_cmd_oper  = '0;
    i_cmd_argA  = '0;
    i_cmd_argB  = '0;
    i_rsp_ready = 1'b0;
    do_reset();

    // reset state
    check_quiet("reset");
    check("reset_x_oper", 32'(o_x_oper), 32'd0);
    check("reset_x_argA", 32'(o_x_argA), 32'd0);
    check("reset_rsp_result", 32'(o_rsp_result), 32'd0);

    // single command, cycle-exact
    push(0, 5, w);
    check("single_nofallthru_busy", 32'(o_busy), 32'd0);
    check("single_nofallthru_x", 32'(o_x_oper), 32'd0);
    tick();
    check("single_issue_busy", 32'(o_busy), 32'd1);
    check("single_x", 32'({o_x_oper, o_x_argA, o_x_argB}),
          32'({tbl[0].oper, tbl[0].a, tbl[0].b}));
    tick();
    check("single_wait_valid", 32'(o_rsp_valid), 32'd0);
    tick();
    check("single_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("single_rsp", 32'({o_rsp_result, o_rsp_status, o_rsp_oper}), 32'({4'h5, 2'b01, 2'b01}));
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check("single_after_valid", 32'(o_rsp_valid), 32'd0);
    check("single_err_cnt", 32'(o_err_cnt), 32'd1);
    check("single_idle", 32'(o_busy), 32'd0);
    check("single_x_kept", 32'(o_x_argA), 32'(tbl[0].a));

    // back-to-back, ready tied high
    do_reset();
    i_rsp_ready = 1'b1;
    hs_q.delete();
    for (int i = 1; i <= 4; i++) begin
      push(i, 10, w);
      check("b2b_no_stall", 32'(w), 32'd0);
    end
    drain(60);
    check("b2b_rsp_count", 32'(hs_q.size()), 32'd4);
    if (hs_q.size() == 4) begin
      for (int k = 0; k < 3; k++) check("b2b_spacing", 32'(hs_q[k+1] - hs_q[k]), 32'd3);
    end
    check("b2b_err_cnt", 32'(o_err_cnt), 32'd3);

    // FIFO full with response held
    do_reset();
    i_rsp_ready = 1'b0;
    for (int i = 5; i <= 9; i++) begin
      push(i, 10, w);
      check("full_fill_no_stall", 32'(w), 32'd0);
    end
    i_cmd_valid = 1'b1;
    i_cmd_oper  = tbl[10].oper;
    i_cmd_argA  = tbl[10].a;
    i_cmd_argB  = tbl[10].b;
    check("full_ready_low", 32'(o_cmd_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("full_ready_held", 32'(o_cmd_ready), 32'd0);
      check("full_rsp_head", 32'(o_rsp_result), 32'(tbl[5].res));
    end
    i_rsp_ready = 1'b1;
    push(10, 10, w);
    check("full_sixth_wait", 32'(w), 32'd1);
    drain(100);
    check("full_err_cnt", 32'(o_err_cnt), 32'd3);

    // response backpressure
    do_reset();
    i_rsp_ready = 1'b0;
    push(11, 5, w);
    push(1, 5, w);
    wait_valid(10);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid", 32'(o_rsp_valid), 32'd1);
      check("bp_rsp", 32'({o_rsp_result, o_rsp_status, o_rsp_oper}),
            32'({tbl[11].res, tbl[11].oper, tbl[11].oper}));
      check("bp_x", 32'({o_x_oper, o_x_argA, o_x_argB}),
            32'({tbl[11].oper, tbl[11].a, tbl[11].b}));
    end
    i_rsp_ready = 1'b1;
    drain(30);
    check("bp_err_cnt", 32'(o_err_cnt), 32'd1);

    // reset mid-WAIT with two queued
    do_reset();
    i_rsp_ready = 1'b0;
    push(0, 5, w);
    push(1, 5, w);
    push(2, 5, w);
    check("midwait_busy", 32'(o_busy), 32'd1);
    check("midwait_valid", 32'(o_rsp_valid), 32'd0);
    do_reset();
    check_quiet("midwait_rst");
    i_rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("midwait_no_stale", 32'({o_rsp_valid, o_busy}), 32'd0);
    end

    // reset mid-RESP with two queued
    do_reset();
    i_rsp_ready = 1'b0;
    push(3, 5, w);
    push(10, 5, w);
    push(11, 5, w);
    wait_valid(10);
    do_reset();
    check_quiet("midresp_rst");
    i_rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("midresp_no_stale", 32'({o_rsp_valid, o_busy}), 32'd0);
    end

    // error counter saturation (2-bit counter)
    do_reset();
    i_rsp_ready = 1'b1;
    push(11, 10, w);
    push(11, 10, w);
    drain(40);
    check("sat_err_two", 32'(o_err_cnt), 32'd2);
    for (int i = 0; i < 3; i++) push(11, 10, w);
    drain(60);
    check("sat_err_max", 32'(o_err_cnt), 32'd3);
    for (int k = 0; k < 3; k++) tick();
    check("sat_err_stays", 32'(o_err_cnt), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
